// File: rtl/jtag_ir_pkg.sv
// Instruction-register constants for the JTAG IR slice: opcode encodings,
// decoded line indices, the capture pattern and the opcode-to-line lookup.
package jtag_ir_pkg;

   // Encodings are held 32 bits wide; the decoder compares a zero-extended IR.
   localparam logic [31:0] E_EXTEST  = 32'h0000_0000;
   localparam logic [31:0] E_IDCODE  = 32'h0000_0001;
   localparam logic [31:0] E_SAMPLE  = 32'h0000_0002;
   localparam logic [31:0] E_PRELOAD = 32'h0000_0003;
   localparam logic [31:0] E_INTEST  = 32'h0000_0004;
   localparam logic [31:0] E_CLAMP   = 32'h0000_0005;
   localparam logic [31:0] E_HIGHZ   = 32'h0000_0006;
   localparam logic [31:0] E_HALT    = 32'h0000_0007;
   localparam logic [31:0] E_DEBUG   = 32'h0000_0008;
   localparam logic [31:0] E_BYPASS  = 32'hFFFF_FFFF;

   localparam int unsigned IDX_BYPASS  = 0;
   localparam int unsigned IDX_EXTEST  = 1;
   localparam int unsigned IDX_IDCODE  = 2;
   localparam int unsigned IDX_SAMPLE  = 3;
   localparam int unsigned IDX_PRELOAD = 4;
   localparam int unsigned IDX_INTEST  = 5;
   localparam int unsigned IDX_CLAMP   = 6;
   localparam int unsigned IDX_HIGHZ   = 7;
   localparam int unsigned IDX_HALT    = 8;
   localparam int unsigned IDX_DEBUG   = 9;

   // Two LSBs loaded on Capture-IR (IEEE 1149.1 fixed pattern).
   localparam logic [1:0] CAPTURE_LSB = 2'b01;

   function automatic logic [31:0] ones_of_width(input int unsigned width);
      logic [31:0] mask;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return mask;
   endfunction

   // Map a zero-extended opcode to its instruction line; anything unlisted
   // (including the all-ones pattern of the actual IR width) is BYPASS.
   function automatic int unsigned op_index(input logic [31:0] op, input int unsigned width);
      int unsigned idx;
      if (op == ones_of_width(width)) begin
         idx = IDX_BYPASS;
      end else begin
         case (op)
            E_EXTEST:  idx = IDX_EXTEST;
            E_IDCODE:  idx = IDX_IDCODE;
            E_SAMPLE:  idx = IDX_SAMPLE;
            E_PRELOAD: idx = IDX_PRELOAD;
            E_INTEST:  idx = IDX_INTEST;
            E_CLAMP:   idx = IDX_CLAMP;
            E_HIGHZ:   idx = IDX_HIGHZ;
            E_HALT:    idx = IDX_HALT;
            E_DEBUG:   idx = IDX_DEBUG;
            default:   idx = IDX_BYPASS;
         endcase
      end
      return idx;
   endfunction

endpackage

// File: rtl/jtag_ir_param_ir_decoder.sv
// Combinational opcode to one-hot instruction decode with private-instruction
// masking; the result is always exactly one-hot.
module ir_decoder
   import jtag_ir_pkg::*;
#(
   parameter int                    IR_WIDTH     = 4,
   parameter int                    INST_COUNT   = 10,
   parameter logic [INST_COUNT-1:0] PRIVATE_MASK = '0
) (
   input  logic [IR_WIDTH-1:0]   opcode,
   input  logic                  unlock,
   output logic [INST_COUNT-1:0] instructions
);

   localparam logic [INST_COUNT-1:0] BYPASS_HOT = INST_COUNT'(1) << IDX_BYPASS;

   logic [31:0]           raw_idx;
   logic [INST_COUNT-1:0] raw_hot;
   logic                  known;
   logic                  blocked;
   logic                  use_bypass;

   assign raw_idx = 32'(op_index(32'(opcode), IR_WIDTH));

   for (genvar gi = 0; gi < INST_COUNT; gi++) begin : g_line
      assign raw_hot[gi] = (raw_idx == 32'(gi));
   end

   // Indices beyond INST_COUNT leave raw_hot empty and fall back to BYPASS.
   assign known      = |raw_hot;
   assign blocked    = (|(raw_hot & PRIVATE_MASK & ~BYPASS_HOT)) && !unlock;
   assign use_bypass = !known || blocked;

   assign instructions = use_bypass ? BYPASS_HOT : raw_hot;

endmodule

// File: rtl/jtag_ir_param.sv
// Parameterised JTAG instruction register: capture/shift path, shift-length
// tracking and the update latch for the raw opcode and its decoded lines.
module jtag_ir_param
   import jtag_ir_pkg::*;
#(
   parameter int                    IR_WIDTH     = 4,
   parameter int                    INST_COUNT   = 10,
   parameter bit                    STRICT_LEN   = 1'b0,
   parameter logic [INST_COUNT-1:0] PRIVATE_MASK = '0
) (
   input  logic                  tck,
   input  logic                  tl_reset,
   input  logic                  tlr_state,
   input  logic                  capture_ir,
   input  logic                  shift_ir,
   input  logic                  update_ir,
   input  logic                  tdi,
   input  logic [IR_WIDTH-3:0]   status_in,
   input  logic                  unlock,
   output logic                  tdo,
   output logic [INST_COUNT-1:0] instructions,
   output logic [IR_WIDTH-1:0]   opcode,
   output logic                  len_err
);

   localparam int                    CW        = $clog2(IR_WIDTH + 1);
   localparam logic [CW-1:0]         CNT_FULL  = CW'(IR_WIDTH);
   localparam logic [IR_WIDTH-1:0]   SHIFT_RST = {{(IR_WIDTH-2){1'b0}}, CAPTURE_LSB};
   localparam logic [IR_WIDTH-1:0]   OP_RST    = IR_WIDTH'(E_IDCODE);
   localparam logic [INST_COUNT-1:0] INST_RST  = INST_COUNT'(1) << IDX_IDCODE;

   logic [IR_WIDTH-1:0]   shift_reg;
   logic [CW-1:0]         cnt_reg;
   logic [IR_WIDTH-1:0]   opcode_reg;
   logic [INST_COUNT-1:0] inst_reg;
   logic                  len_err_reg;
   logic [INST_COUNT-1:0] decoded;
   logic                  accept;

   ir_decoder #(
      .IR_WIDTH     (IR_WIDTH),
      .INST_COUNT   (INST_COUNT),
      .PRIVATE_MASK (PRIVATE_MASK)
   ) u_decoder (
      .opcode       (shift_reg),
      .unlock       (unlock),
      .instructions (decoded)
   );

   // Without strict length checking every update is taken.
   assign accept = !STRICT_LEN || (cnt_reg == CNT_FULL);

   always_ff @(posedge tck or negedge tl_reset) begin
      if (!tl_reset) begin
         shift_reg   <= SHIFT_RST;
         cnt_reg     <= '0;
         opcode_reg  <= OP_RST;
         inst_reg    <= INST_RST;
         len_err_reg <= 1'b0;
      end else if (tlr_state) begin
         shift_reg   <= SHIFT_RST;
         cnt_reg     <= '0;
         opcode_reg  <= OP_RST;
         inst_reg    <= INST_RST;
         len_err_reg <= 1'b0;
      end else begin
         // The latch sees the pre-edge shift_reg, so a coincident capture is safe.
         if (update_ir) begin
            if (accept) begin
               opcode_reg  <= shift_reg;
               inst_reg    <= decoded;
               len_err_reg <= 1'b0;
            end else begin
               len_err_reg <= 1'b1;
            end
         end
         if (capture_ir) begin
            shift_reg <= {status_in, CAPTURE_LSB};
            cnt_reg   <= '0;
         end else if (shift_ir) begin
            shift_reg <= {tdi, shift_reg[IR_WIDTH-1:1]};
            if (cnt_reg != CNT_FULL) begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   end

   assign tdo          = shift_reg[0];
   assign opcode       = opcode_reg;
   assign instructions = inst_reg;
   assign len_err      = len_err_reg;

endmodule

// File: tb/tb_jtag_ir_param.sv
// Bench for jtag_ir_param: a lenient and a strict-length instance share one
// stimulus stream; a table of scans plus hand-written corner sequences.
module tb_jtag_ir_param;

   localparam int            IRW   = 4;
   localparam int            NI    = 10;
   localparam logic [NI-1:0] PMASK = 10'h100;   // HALT is private

   logic            tck = 1'b0;
   logic            tl_reset, tlr_state, capture_ir, shift_ir, update_ir, tdi, unlock;
   logic [IRW-3:0]  status_in;
   logic            tdo_n, tdo_s, err_n, err_s;
   logic [NI-1:0]   inst_n, inst_s;
   logic [IRW-1:0]  op_n, op_s;

   jtag_ir_param #(.IR_WIDTH(IRW), .INST_COUNT(NI), .STRICT_LEN(1'b0), .PRIVATE_MASK(PMASK)) dut (
      .tck(tck), .tl_reset(tl_reset), .tlr_state(tlr_state), .capture_ir(capture_ir),
      .shift_ir(shift_ir), .update_ir(update_ir), .tdi(tdi), .status_in(status_in),
      .unlock(unlock), .tdo(tdo_n), .instructions(inst_n), .opcode(op_n), .len_err(err_n));

   jtag_ir_param #(.IR_WIDTH(IRW), .INST_COUNT(NI), .STRICT_LEN(1'b1), .PRIVATE_MASK(PMASK)) dut_s (
      .tck(tck), .tl_reset(tl_reset), .tlr_state(tlr_state), .capture_ir(capture_ir),
      .shift_ir(shift_ir), .update_ir(update_ir), .tdi(tdi), .status_in(status_in),
      .unlock(unlock), .tdo(tdo_s), .instructions(inst_s), .opcode(op_s), .len_err(err_s));

   always #5 tck = ~tck;

   int n_cmp = 0;
   int n_mis = 0;

   typedef struct {
      logic [3:0] op;  logic [1:0] status; logic unl; int nsh;
      logic [9:0] inst_n; logic [3:0] op_n;
      logic [9:0] inst_s; logic [3:0] op_s; logic err_s;
   } vec_t;

   typedef struct {
      string name;
      logic [9:0] inst_n; logic [3:0] op_n;
      logic [9:0] inst_s; logic [3:0] op_s; logic err_s;
   } exp_t;

   exp_t sb[$];
   vec_t vt[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge tck);
   endtask

   task automatic check_latched;
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      $display("txn %s: inst_n=%h op_n=%h | inst_s=%h op_s=%h len_err_s=%b",
               e.name, inst_n, op_n, inst_s, op_s, err_s);
      chk({e.name, ".inst_n"},  inst_n, e.inst_n);
      chk({e.name, ".op_n"},    op_n,   e.op_n);
      chk({e.name, ".err_n"},   err_n,  1'b0);
      chk({e.name, ".inst_s"},  inst_s, e.inst_s);
      chk({e.name, ".op_s"},    op_s,   e.op_s);
      chk({e.name, ".err_s"},   err_s,  e.err_s);
   endtask

   // Capture, shift v.nsh bits (tdi = op[i%4]), update; tdo is checked per shift.
   task automatic run_vec(input vec_t v, input string name);
      logic [3:0] cap;
      logic       e;
      cap = {v.status, 2'b01};
      status_in = v.status;
      unlock = v.unl;
      capture_ir = 1'b1;
      tick();
      capture_ir = 1'b0;
      shift_ir = 1'b1;
      for (int i = 0; i < v.nsh; i++) begin
         e = (i < 4) ? cap[i] : v.op[(i-4)%4];
         chk({name, ".tdo_n"}, tdo_n, e);
         chk({name, ".tdo_s"}, tdo_s, e);
         tdi = v.op[i%4];
         tick();
      end
      shift_ir = 1'b0;
      tdi = 1'b0;
      update_ir = 1'b1;
      sb.push_back('{name, v.inst_n, v.op_n, v.inst_s, v.op_s, v.err_s});
      tick();
      update_ir = 1'b0;
      check_latched();
   endtask

   task automatic check_idcode(input string name, input logic exp_err_s);
      chk({name, ".inst_n"}, inst_n, 10'h004);
      chk({name, ".op_n"},   op_n,   4'h1);
      chk({name, ".tdo_n"},  tdo_n,  1'b1);
      chk({name, ".err_n"},  err_n,  1'b0);
      chk({name, ".inst_s"}, inst_s, 10'h004);
      chk({name, ".op_s"},   op_s,   4'h1);
      chk({name, ".err_s"},  err_s,  exp_err_s);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: no summary reached by time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] pat;
      vec_t       tmp;

      //          op     st    unl nsh  inst_n   op_n   inst_s   op_s  err_s
      vt[0]  = '{4'hF, 2'b10, 1'b0, 4, 10'h001, 4'hF, 10'h001, 4'hF, 1'b0};
      vt[1]  = '{4'hA, 2'b00, 1'b0, 4, 10'h001, 4'hA, 10'h001, 4'hA, 1'b0};
      vt[2]  = '{4'h7, 2'b01, 1'b0, 4, 10'h001, 4'h7, 10'h001, 4'h7, 1'b0};
      vt[3]  = '{4'h7, 2'b01, 1'b1, 4, 10'h100, 4'h7, 10'h100, 4'h7, 1'b0};
      vt[4]  = '{4'h0, 2'b11, 1'b0, 4, 10'h002, 4'h0, 10'h002, 4'h0, 1'b0};
      vt[5]  = '{4'h2, 2'b10, 1'b0, 4, 10'h008, 4'h2, 10'h008, 4'h2, 1'b0};
      vt[6]  = '{4'h2, 2'b10, 1'b0, 2, 10'h001, 4'hA, 10'h008, 4'h2, 1'b1};
      vt[7]  = '{4'h6, 2'b00, 1'b0, 4, 10'h080, 4'h6, 10'h080, 4'h6, 1'b0};
      vt[8]  = '{4'h8, 2'b01, 1'b0, 4, 10'h200, 4'h8, 10'h200, 4'h8, 1'b0};
      vt[9]  = '{4'h1, 2'b10, 1'b0, 4, 10'h004, 4'h1, 10'h004, 4'h1, 1'b0};
      vt[10] = '{4'h5, 2'b11, 1'b0, 3, 10'h001, 4'hB, 10'h004, 4'h1, 1'b1};
      vt[11] = '{4'h3, 2'b00, 1'b0, 4, 10'h010, 4'h3, 10'h010, 4'h3, 1'b0};
      vt[12] = '{4'hE, 2'b01, 1'b1, 4, 10'h001, 4'hE, 10'h001, 4'hE, 1'b0};
      vt[13] = '{4'h1, 2'b00, 1'b0, 6, 10'h020, 4'h4, 10'h020, 4'h4, 1'b0};

      tl_reset = 1'b1; tlr_state = 1'b0; capture_ir = 1'b0; shift_ir = 1'b0;
      update_ir = 1'b0; tdi = 1'b0; unlock = 1'b0; status_in = 2'b00;

      #3 tl_reset = 1'b0;
      #4 check_idcode("reset", 1'b0);
      tick();
      tl_reset = 1'b1;
      tick();

      // First update with no shift: lenient takes IDCODE, strict rejects.
      update_ir = 1'b1;
      sb.push_back('{"first_update", 10'h004, 4'h1, 10'h004, 4'h1, 1'b1});
      tick();
      update_ir = 1'b0;
      check_latched();

      // Capture status 2'b10, shift zeros: tdo must read 1,0,0,1.
      status_in = 2'b10;
      capture_ir = 1'b1;
      tick();
      capture_ir = 1'b0;
      shift_ir = 1'b1;
      pat = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         chk("capture_tdo_n", tdo_n, pat[i]);
         chk("capture_tdo_s", tdo_s, pat[i]);
         tdi = 1'b0;
         tick();
      end
      shift_ir = 1'b0;
      chk("capture_inst_n", inst_n, 10'h004);

      for (int k = 0; k < 14; k++) begin
         run_vec(vt[k], $sformatf("vec%0d", k));
      end

      // Update and capture on the same edge: old contents latch, capture loads.
      status_in = 2'b01;
      capture_ir = 1'b1;
      tick();
      capture_ir = 1'b0;
      shift_ir = 1'b1;
      pat = 4'h3;
      for (int i = 0; i < 4; i++) begin
         tdi = pat[i];
         tick();
      end
      shift_ir = 1'b0;
      update_ir = 1'b1;
      capture_ir = 1'b1;
      sb.push_back('{"upd_cap", 10'h010, 4'h3, 10'h010, 4'h3, 1'b0});
      tick();
      update_ir = 1'b0;
      capture_ir = 1'b0;
      check_latched();
      shift_ir = 1'b1;
      pat = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         chk("upd_cap_tdo_n", tdo_n, pat[i]);
         chk("upd_cap_tdo_s", tdo_s, pat[i]);
         tdi = 1'b0;
         tick();
      end
      shift_ir = 1'b0;
      update_ir = 1'b1;
      sb.push_back('{"after_upd_cap", 10'h002, 4'h0, 10'h002, 4'h0, 1'b0});
      tick();
      update_ir = 1'b0;
      check_latched();

      // Asynchronous reset in the middle of a shift.
      status_in = 2'b10;
      capture_ir = 1'b1;
      tick();
      capture_ir = 1'b0;
      shift_ir = 1'b1;
      tdi = 1'b1;
      tick();
      tick();
      tl_reset = 1'b0;
      #1 check_idcode("async_reset", 1'b0);
      shift_ir = 1'b0;
      tdi = 1'b0;
      tick();
      tl_reset = 1'b1;
      tick();

      // Synchronous Test-Logic-Reset, entered with the strict len_err set.
      tmp = '{4'h2, 2'b10, 1'b0, 2, 10'h001, 4'hA, 10'h004, 4'h1, 1'b1};
      run_vec(tmp, "pre_tlr");
      capture_ir = 1'b1;
      tick();
      capture_ir = 1'b0;
      shift_ir = 1'b1;
      tdi = 1'b1;
      tick();
      tick();
      tlr_state = 1'b1;
      #1;
      chk("tlr_pre_edge_inst_n", inst_n, 10'h001);
      chk("tlr_pre_edge_err_s",  err_s,  1'b1);
      tick();
      tlr_state = 1'b0;
      shift_ir = 1'b0;
      tdi = 1'b0;
      check_idcode("tlr_state", 1'b0);

      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
